i3c_target_rx: RTL

- Target-side SDR receiver for the I3C bus: the listening end of the controller that drives SCL/SDA.
- Samples SCL/SDA and detects START, repeated START and STOP.
- Decodes the address header, ACKs its own address on private writes, and deserialises data bytes with T-bit (parity) checking.
- Hands completed bytes to the core through a one-entry valid/ready buffer, and reports bus events and errors.

---
 rtl/i3c_target_rx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/i3c_target_rx.sv
// I3C SDR target receiver: bus-condition detection, address header ACK,
// data deserialisation with T-bit check and a one-entry valid/ready buffer.
// Define I3C_TARGET_RX_BCAST_EN to also ACK the broadcast header 7'h7E/W.
module i3c_target_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  input  logic [6:0] target_addr_i,
  output logic [7:0] rx_data_o,
  output logic       rx_bcast_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       start_det_o,
  output logic       stop_det_o,
  output logic       err_parity_o,
  output logic       err_overflow_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK,
    ST_DATA,
    ST_TBIT,
    ST_IGNORE
  } state_e;

  localparam logic [6:0] BCAST_ADDR = 7'h7E;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       ack_q;
  logic       ack_fell_q;
  logic       bcast_frame_q;
  logic       sda_q;
  logic [7:0] rx_data_q;
  logic       rx_bcast_q;
  logic       rx_valid_q;
  logic       start_det_q, stop_det_q, err_parity_q, err_overflow_q;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall;
  logic       start_cond, stop_cond;
  logic [7:0] shift_d;
  logic       bcast_hit, addr_match, parity_ok, pop;

  // Pins idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_hist_q;
  assign scl_fall   = ~scl_s & scl_hist_q;
  assign start_cond = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
  assign stop_cond  = scl_s & scl_hist_q & sda_s & ~sda_hist_q;
  assign shift_d    = {shift_q[6:0], sda_s};

`ifdef I3C_TARGET_RX_BCAST_EN
  assign bcast_hit = (shift_q[6:0] == BCAST_ADDR);
`else
  assign bcast_hit = 1'b0;
`endif

  // On the RnW sampling edge shift_q[6:0] already holds A6..A0.
  assign addr_match = (shift_q[6:0] == target_addr_i) | bcast_hit;
  assign parity_ok  = (sda_s == ~^shift_q);
  assign pop        = rx_valid_q & rx_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      ack_q          <= 1'b0;
      ack_fell_q     <= 1'b0;
      bcast_frame_q  <= 1'b0;
      sda_q          <= 1'b1;
      rx_data_q      <= '0;
      rx_bcast_q     <= 1'b0;
      rx_valid_q     <= 1'b0;
      start_det_q    <= 1'b0;
      stop_det_q     <= 1'b0;
      err_parity_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults; a later assignment in this block wins.
      start_det_q    <= 1'b0;
      stop_det_q     <= 1'b0;
      err_parity_q   <= 1'b0;
      err_overflow_q <= 1'b0;
      if (pop) rx_valid_q <= 1'b0;

      if (start_cond) begin
        state_q     <= ST_ADDR;
        bit_cnt_q   <= '0;
        sda_q       <= 1'b1;
        start_det_q <= 1'b1;
      end else if (stop_cond) begin
        state_q    <= ST_IDLE;
        bit_cnt_q  <= '0;
        sda_q      <= 1'b1;
        stop_det_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_ADDR: begin
            if (scl_rise) begin
              shift_q <= shift_d;
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q     <= '0;
                ack_q         <= addr_match & ~sda_s;
                bcast_frame_q <= bcast_hit;
                ack_fell_q    <= 1'b0;
                state_q       <= ST_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          ST_ACK: begin
            if (scl_fall && !ack_fell_q) begin
              sda_q      <= ~ack_q;
              ack_fell_q <= 1'b1;
            end else if (scl_rise && ack_fell_q) begin
              state_q <= ack_q ? ST_DATA : ST_IGNORE;
            end
          end
          ST_DATA: begin
            // Release the ACK drive once the controller takes SCL low again.
            if (scl_fall) sda_q <= 1'b1;
            if (scl_rise) begin
              shift_q <= shift_d;
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q <= '0;
                state_q   <= ST_TBIT;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          ST_TBIT: begin
            if (scl_rise) begin
              if (parity_ok) begin
                state_q <= ST_DATA;
                if (!rx_valid_q || rx_ready_i) begin
                  rx_data_q  <= shift_q;
                  rx_bcast_q <= bcast_frame_q;
                  rx_valid_q <= 1'b1;
                end else begin
                  err_overflow_q <= 1'b1;
                end
              end else begin
                err_parity_q <= 1'b1;
                state_q      <= ST_IGNORE;
              end
            end
          end
          ST_IGNORE: sda_q <= 1'b1;
          default:   state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign sda_o          = sda_q;
  assign rx_data_o      = rx_data_q;
  assign rx_bcast_o     = rx_bcast_q;
  assign rx_valid_o     = rx_valid_q;
  assign start_det_o    = start_det_q;
  assign stop_det_o     = stop_det_q;
  assign err_parity_o   = err_parity_q;
  assign err_overflow_o = err_overflow_q;

endmodule
